// File: rtl/codec_dac_transmitter_if.sv
// Sample stream from the controller into the DAC transmitter.
// The master offers samples with in_valid/in_data, and the slave answers with in_ready.
interface codec_dac_transmitter_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/codec_dac_transmitter.sv
// I2S-style DAC transmitter. Each queued mono sample is played on both slots of one frame.
// The codec drives BCLK and DACLRC. Both are oversampled and synchronised into clk.
module codec_dac_transmitter #(
   parameter int DATA_W      = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   codec_dac_transmitter_if.slave        stream,
   input  logic                          BCLK,
   input  logic                          DACLRC,
   output logic                          DACDAT,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {IDLE, WAIT_L, DELAY, SHIFT, PAD} state_t;

   logic [SYNC_STAGES-1:0] bclk_sync_reg;
   logic [SYNC_STAGES-1:0] lrc_sync_reg;
   logic                   bclk_prev_reg;
   logic                   lrc_latched_reg;
   logic                   bclk_s;
   logic                   lrc_s;
   logic                   bclk_fall;
   logic                   slot_start;
   logic                   left_start;
   logic                   right_start;

   logic [DATA_W-1:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [LVL_W-1:0]       level_reg;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic [DATA_W-1:0]      head;

   state_t                 state_reg;
   logic [DATA_W-1:0]      hold_reg;
   logic [DATA_W-1:0]      shreg_reg;
   logic [CNT_W-1:0]       cnt_reg;
   logic                   dacdat_reg;
   logic                   underrun_reg;

   assign bclk_s      = bclk_sync_reg[SYNC_STAGES-1];
   assign lrc_s       = lrc_sync_reg[SYNC_STAGES-1];
   assign bclk_fall   = bclk_prev_reg & ~bclk_s;
   assign slot_start  = bclk_fall & (lrc_s != lrc_latched_reg);
   assign left_start  = slot_start & ~lrc_s;
   assign right_start = slot_start & lrc_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         bclk_sync_reg   <= '0;
         lrc_sync_reg    <= '0;
         bclk_prev_reg   <= 1'b0;
         lrc_latched_reg <= 1'b0;
      end else begin
         bclk_sync_reg <= {bclk_sync_reg[SYNC_STAGES-2:0], BCLK};
         lrc_sync_reg  <= {lrc_sync_reg[SYNC_STAGES-2:0], DACLRC};
         bclk_prev_reg <= bclk_s;
         if (bclk_fall) begin
            lrc_latched_reg <= lrc_s;
         end
      end
   end

   // A full FIFO refuses data even when a pop happens in the same cycle.
   assign full            = (level_reg == LVL_W'(FIFO_DEPTH));
   assign empty           = (level_reg == '0);
   assign stream.in_ready = enable & ~full & ~rst;
   assign push            = stream.in_valid & stream.in_ready;
   assign pop             = left_start & enable & (state_reg != IDLE) & ~empty;
   assign head            = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= stream.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)      level_reg <= level_reg + LVL_W'(1);
         else if (!push && pop) level_reg <= level_reg - LVL_W'(1);
      end
   end

   // A slot start always wins over shifting, so a short slot truncates the word cleanly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         hold_reg     <= '0;
         shreg_reg    <= '0;
         cnt_reg      <= '0;
         dacdat_reg   <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         underrun_reg <= 1'b0;
         if (!enable) begin
            state_reg  <= IDLE;
            dacdat_reg <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: state_reg <= WAIT_L;
               default: begin
                  if (left_start) begin
                     if (empty) begin
                        hold_reg     <= '0;
                        shreg_reg    <= '0;
                        underrun_reg <= 1'b1;
                     end else begin
                        hold_reg  <= head;
                        shreg_reg <= head;
                     end
                     cnt_reg    <= CNT_W'(DATA_W);
                     dacdat_reg <= 1'b0;
                     state_reg  <= DELAY;
                  end else if (right_start && state_reg != WAIT_L) begin
                     shreg_reg  <= hold_reg;
                     cnt_reg    <= CNT_W'(DATA_W);
                     dacdat_reg <= 1'b0;
                     state_reg  <= DELAY;
                  end else if (bclk_fall && (state_reg == DELAY || state_reg == SHIFT)) begin
                     dacdat_reg <= shreg_reg[DATA_W-1];
                     shreg_reg  <= shreg_reg << 1;
                     cnt_reg    <= cnt_reg - CNT_W'(1);
                     state_reg  <= (cnt_reg == CNT_W'(1)) ? PAD : SHIFT;
                  end else if (bclk_fall && state_reg == PAD) begin
                     dacdat_reg <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign DACDAT     = dacdat_reg;
   assign underrun   = underrun_reg;
   assign fifo_level = level_reg;
endmodule

// File: tb/tb_codec_dac_transmitter.sv
// Randomised bench for codec_dac_transmitter. A slot-level model predicts every serial bit,
// the FIFO level, in_ready and the underrun pulses.
module tb_codec_dac_transmitter;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       BCLK;
   logic       DACLRC;
   logic       DACDAT;
   logic       underrun;
   logic [3:0] fifo_level;

   codec_dac_transmitter_if #(.DATA_W(DATA_W)) stream ();

   codec_dac_transmitter #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .stream     (stream),
      .BCLK       (BCLK),
      .DACLRC     (DACLRC),
      .DACDAT     (DACDAT),
      .underrun   (underrun),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state: queued samples, word of the current frame, and the slot bit position.
   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] hold_m;
   bit                armed_m;
   bit                prev_lrc_m;
   bit                en_m;
   int                bit_idx_m;
   int                exp_underruns = 0;
   int                seen_underruns = 0;

   always @(posedge clk) begin
      if (underrun === 1'b1) seen_underruns <= seen_underruns + 1;
   end

   task automatic model_reset();
      q.delete();
      armed_m    = 1'b0;
      prev_lrc_m = 1'b0;
      bit_idx_m  = 0;
      hold_m     = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      enable          = 1'b0;
      en_m            = 1'b0;
      stream.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic set_enable(input bit v);
      @(negedge clk);
      enable = v;
      en_m   = v;
      if (!v) armed_m = 1'b0;
   endtask

   task automatic push(input logic [DATA_W-1:0] d, input string tag);
      bit exp_rdy;
      @(negedge clk);
      stream.in_valid = 1'b1;
      stream.in_data  = d;
      #1;
      exp_rdy = en_m && (q.size() < DEPTH);
      checks++;
      if (stream.in_ready !== exp_rdy) begin
         failures++;
         $display("FAIL %s in_ready: got %b want %b", tag, stream.in_ready, exp_rdy);
      end
      if (exp_rdy) q.push_back(d);
      $display("push %s data=%h accepted=%0d level_model=%0d", tag, d, exp_rdy, q.size());
      @(negedge clk);
      stream.in_valid = 1'b0;
   endtask

   // One BCLK period of 8 clk: falling pin edge, then sampling well inside the high phase.
   task automatic bclk_cycle(input bit lrc, input string tag);
      logic exp_bit;
      bit   exp_rdy;
      @(negedge clk);
      BCLK   = 1'b0;
      DACLRC = lrc;
      if (lrc != prev_lrc_m) begin
         if (en_m && lrc == 1'b0) begin
            armed_m = 1'b1;
            if (q.size() > 0) hold_m = q.pop_front();
            else begin
               hold_m = '0;
               exp_underruns++;
            end
         end
         bit_idx_m = 0;
      end else begin
         bit_idx_m++;
      end
      prev_lrc_m = lrc;
      exp_bit = (armed_m && bit_idx_m >= 1 && bit_idx_m <= DATA_W) ? hold_m[DATA_W - bit_idx_m] : 1'b0;
      exp_rdy = en_m && (q.size() < DEPTH);
      repeat (4) @(negedge clk);
      BCLK = 1'b1;
      repeat (2) @(negedge clk);
      checks += 3;
      if (DACDAT !== exp_bit) begin
         failures++;
         $display("FAIL %s DACDAT bit %0d: got %b want %b", tag, bit_idx_m, DACDAT, exp_bit);
      end
      if (fifo_level !== 4'(q.size())) begin
         failures++;
         $display("FAIL %s fifo_level: got %0d want %0d", tag, fifo_level, q.size());
      end
      if (stream.in_ready !== exp_rdy) begin
         failures++;
         $display("FAIL %s in_ready: got %b want %b", tag, stream.in_ready, exp_rdy);
      end
      @(negedge clk);
   endtask

   task automatic slot(input bit lrc, input int n, input string tag);
      for (int i = 0; i < n; i++) bclk_cycle(lrc, tag);
      $display("slot %s lrc=%0d bclks=%0d word=%h level_model=%0d", tag, lrc, n, hold_m, q.size());
   endtask

   task automatic check_underruns(input string tag);
      checks++;
      if (seen_underruns != exp_underruns) begin
         failures++;
         $display("FAIL %s underrun pulses: got %0d want %0d", tag, seen_underruns, exp_underruns);
      end
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      enable          = 1'b1;
      stream.in_valid = 1'b0;
      stream.in_data  = '0;
      BCLK            = 1'b1;
      DACLRC          = 1'b0;
      repeat (3) @(negedge clk);
      checks += 4;
      if (DACDAT !== 1'b0)          begin failures++; $display("FAIL reset DACDAT: got %b want 0", DACDAT); end
      if (stream.in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready: got %b want 0", stream.in_ready); end
      if (fifo_level !== 4'd0)      begin failures++; $display("FAIL reset fifo_level: got %0d want 0", fifo_level); end
      if (underrun !== 1'b0)        begin failures++; $display("FAIL reset underrun: got %b want 0", underrun); end
      rst    = 1'b0;
      enable = 1'b0;
      en_m   = 1'b0;
      model_reset();
      // Reset while all-ones bits are being shifted out.
      set_enable(1'b1);
      push(16'hFFFF, "rst_push");
      push(16'h1234, "rst_push");
      slot(1'b1, 3, "rst_warm");
      slot(1'b0, 6, "rst_shift");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks += 3;
      if (DACDAT !== 1'b0)          begin failures++; $display("FAIL midreset DACDAT: got %b want 0", DACDAT); end
      if (stream.in_ready !== 1'b0) begin failures++; $display("FAIL midreset in_ready: got %b want 0", stream.in_ready); end
      if (fifo_level !== 4'd0)      begin failures++; $display("FAIL midreset fifo_level: got %0d want 0", fifo_level); end
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      enable = 1'b0;
      en_m   = 1'b0;
      model_reset();
      $display("test_reset done");
   endtask

   task automatic test_basic_frame();
      do_reset();
      set_enable(1'b1);
      push(16'hA5C3, "basic");
      slot(1'b1, 4, "basic_warm");
      slot(1'b0, 32, "basic_L");
      slot(1'b1, 32, "basic_R");
      check_underruns("basic");
   endtask

   task automatic test_fill();
      do_reset();
      set_enable(1'b1);
      for (int i = 0; i < DEPTH + 1; i++) push(16'($urandom), "fill");
      @(negedge clk);
      checks += 2;
      if (fifo_level !== 4'd8)      begin failures++; $display("FAIL fill level: got %0d want 8", fifo_level); end
      if (stream.in_ready !== 1'b0) begin failures++; $display("FAIL fill in_ready: got %b want 0", stream.in_ready); end
      slot(1'b1, 2, "fill_warm");
      bclk_cycle(1'b0, "fill_pop");
      slot(1'b0, 31, "fill_L");
      slot(1'b1, 32, "fill_R");
      check_underruns("fill");
   endtask

   task automatic test_underrun();
      do_reset();
      set_enable(1'b1);
      slot(1'b1, 3, "ur_warm");
      slot(1'b0, 32, "ur_L");
      slot(1'b1, 32, "ur_R");
      check_underruns("underrun");
   endtask

   task automatic test_enable_toggle();
      do_reset();
      set_enable(1'b1);
      for (int i = 0; i < 4; i++) push(16'($urandom), "en");
      slot(1'b1, 3, "en_warm");
      slot(1'b0, 8, "en_L");
      set_enable(1'b0);
      @(negedge clk);
      checks += 3;
      if (DACDAT !== 1'b0)          begin failures++; $display("FAIL en_off DACDAT: got %b want 0", DACDAT); end
      if (stream.in_ready !== 1'b0) begin failures++; $display("FAIL en_off in_ready: got %b want 0", stream.in_ready); end
      if (fifo_level !== 4'd3)      begin failures++; $display("FAIL en_off level: got %0d want 3", fifo_level); end
      slot(1'b0, 24, "en_off_L");
      slot(1'b1, 10, "en_off_R");
      set_enable(1'b1);
      slot(1'b1, 22, "en_re_R");
      slot(1'b0, 32, "en_resume_L");
      slot(1'b1, 32, "en_resume_R");
      check_underruns("enable_toggle");
   endtask

   task automatic test_short_slot();
      do_reset();
      set_enable(1'b1);
      push(16'($urandom), "short");
      push(16'($urandom), "short");
      slot(1'b1, 3, "short_warm");
      for (int f = 0; f < 2; f++) begin
         slot(1'b0, 12, "short_L");
         slot(1'b1, 12, "short_R");
      end
      check_underruns("short_slot");
   endtask

   task automatic test_random();
      do_reset();
      set_enable(1'b1);
      slot(1'b1, 3, "rnd_warm");
      for (int f = 0; f < 8; f++) begin
         int n;
         n = int'($urandom_range(0, 2));
         for (int k = 0; k < n; k++) push(16'($urandom), "rnd");
         slot(1'b0, int'($urandom_range(6, 34)), "rnd_L");
         slot(1'b1, int'($urandom_range(6, 34)), "rnd_R");
      end
      check_underruns("random");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_fill();
      test_underrun();
      test_enable_toggle();
      test_short_slot();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
